frame_buffer_ram: RTL

//  Parametrised single-clock frame buffer between the camera pixel stream and the VGA/readout side.

---
 rtl/frame_buffer_pkg.sv | 18 +
 rtl/fb_dpram.sv | 30 +++
 rtl/frame_buffer_ram.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_pkg.sv
// Frame buffer shared types: FSM states, frame counter width, depth helper.
// Imported by frame_buffer_ram.
package frame_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_CAPTURE,
        ST_CLEAR
    } fb_state_e;

    localparam int FRAME_CNT_W = 8;

    function automatic int fb_depth(input int h_pix, input int v_pix);
        return h_pix * v_pix;
    endfunction

endpackage

// File: rtl/fb_dpram.sv
// Plain dual-address synchronous RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents.
module fb_dpram #(
    parameter int AW = 15,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer_ram.sv
// Camera frame buffer: SOF-framed capture, clear sweep, registered read port.
// Define RDW_BYPASS_EN for write-first read/write collisions (read-first otherwise).
module frame_buffer_ram
    import frame_buffer_pkg::*;
#(
    parameter int            AW        = 15,
    parameter int            DW        = 12,
    parameter int            H_PIX     = 160,
    parameter int            V_PIX     = 120,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cap_en,
    input  logic                   sof,
    input  logic                   px_valid,
    input  logic [DW-1:0]          px_data,
    input  logic                   clear_req,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   short_frame,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [DW-1:0]          rd_data,
    output logic                   rd_valid
);

    localparam int            DEPTH     = fb_depth(H_PIX, V_PIX);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    if (DEPTH > (2 ** AW)) begin : g_depth_chk
        $error("frame_buffer_ram: H_PIX*V_PIX exceeds 2**AW");
    end

    fb_state_e                state_q, state_d;
    logic [AW-1:0]            wr_addr_q, wr_addr_d;
    logic                     done_q, done_d;
    logic                     short_q, short_d;
    logic [FRAME_CNT_W-1:0]   cnt_q, cnt_d;

    logic                     cap_wr;
    logic                     cap_last;
    logic [AW-1:0]            cap_addr;

    logic                     ram_we;
    logic [AW-1:0]            ram_waddr;
    logic [DW-1:0]            ram_wdata;
    logic [DW-1:0]            ram_rdata;

    logic                     rd_oor;
    logic                     byp_hit;
    logic                     rd_valid_q;
    logic                     rd_zero_q;
    logic                     rd_byp_q;
    logic [DW-1:0]            rd_byp_data_q;

    // A pixel arriving with SOF always lands at address 0 of the new frame.
    always_comb begin
        cap_addr = sof ? '0 : wr_addr_q;
        cap_wr   = px_valid &&
                   ((state_q == ST_CAPTURE) ||
                    ((state_q == ST_WAIT_SOF) && sof));
        cap_last = cap_wr && (cap_addr == LAST_ADDR);
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        done_d    = 1'b0;
        short_d   = short_q;
        cnt_d     = cnt_q;
        ram_we    = 1'b0;
        ram_waddr = cap_addr;
        ram_wdata = px_data;

        unique case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    wr_addr_d = '0;
                    short_d   = 1'b0;
                end else if (cap_en) begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (sof) begin
                    state_d   = ST_CAPTURE;
                    wr_addr_d = cap_addr + AW'(px_valid);
                end else if (!cap_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (sof) begin
                    short_d = 1'b1;
                end
                wr_addr_d = cap_addr + AW'(px_valid);
            end
            ST_CLEAR: begin
                ram_we    = 1'b1;
                ram_waddr = wr_addr_q;
                ram_wdata = CLEAR_VAL;
                if (wr_addr_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    wr_addr_d = '0;
                end else begin
                    wr_addr_d = wr_addr_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (cap_wr) begin
            ram_we = 1'b1;
            if (cap_last) begin
                done_d    = 1'b1;
                cnt_d     = cnt_q + FRAME_CNT_W'(1);
                wr_addr_d = '0;
                state_d   = cap_en ? ST_WAIT_SOF : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            wr_addr_q <= '0;
            done_q    <= 1'b0;
            short_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            done_q    <= done_d;
            short_q   <= short_d;
            cnt_q     <= cnt_d;
        end
    end

    fb_dpram #(
        .AW(AW),
        .DW(DW)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(ram_wdata),
        .re_i   (rd_en),
        .raddr_i(rd_addr),
        .rdata_o(ram_rdata)
    );

    assign rd_oor = ({1'b0, rd_addr} >= DEPTH_W);

`ifdef RDW_BYPASS_EN
    assign byp_hit = ram_we && (ram_waddr == rd_addr);
`else
    assign byp_hit = 1'b0;
`endif

    // Flags only move with rd_en, so rd_data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q    <= 1'b0;
            rd_zero_q     <= 1'b1;
            rd_byp_q      <= 1'b0;
            rd_byp_data_q <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rd_zero_q     <= rd_oor;
                rd_byp_q      <= byp_hit;
                rd_byp_data_q <= ram_wdata;
            end
        end
    end

    assign rd_data     = rd_zero_q ? '0 :
                         rd_byp_q  ? rd_byp_data_q : ram_rdata;
    assign rd_valid    = rd_valid_q;
    assign busy        = (state_q == ST_CAPTURE) || (state_q == ST_CLEAR);
    assign frame_done  = done_q;
    assign short_frame = short_q;
    assign frame_cnt   = cnt_q;

endmodule
